traffic_light_ctrl: RTL and testbench

Two-road intersection controller (main road / side road). Timed Moore FSM that sequences the red/yellow/green lamps for both roads and latches pedestrian requests. It sits directly upstream of the `mux2to1` display stage: `sel` drives the mux select input, choosing between the main-road and side-road display sources. Main road rests in green; side road is served only on demand.

---
 rtl/traffic_light_ctrl.sv | 149 ++++++++++++++
 tb/tb_traffic_light_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_light_ctrl.sv
// traffic_light_ctrl
//
// Two-road intersection controller. A timed Moore FSM sequences the lamps
// for the main road and the side road. The main road rests in green. The
// side road is served only on demand: a vehicle on the side sensor, or a
// latched pedestrian request.
//
// Parameters:
//   GREEN_CYC  - green duration (minimum green for main, fixed green for side)
//   YELLOW_CYC - yellow duration, both roads
//   ALLRED_CYC - all-red clearance duration
//   CNT_W      - phase timer width; every duration must be in 1 .. 2**CNT_W
//
// Ports:
//   clk         in   rising-edge clock
//   rst_n       in   asynchronous active-low reset
//   side_req    in   side-road vehicle sensor (level, sampled every cycle)
//   ped_req     in   pedestrian button (pulse or level)
//   main_lt     out  main-road lamps {red, yellow, green}, one-hot
//   side_lt     out  side-road lamps {red, yellow, green}, one-hot
//   ped_walk    out  walk signal for crossing the main road (SIDE_G only)
//   ped_pending out  latched pedestrian request not yet served
//   sel         out  display mux select: 0 = main source, 1 = side source
//   dbg_state   out  raw FSM state register, for observation only
//
// Handshake: there is no valid/ready pair. side_req is a level that is
// sampled on every rising edge. A ped_req seen on any rising edge is latched
// into ped_pending and held until the next SIDE_G phase serves it.
module traffic_light_ctrl #(
  parameter int GREEN_CYC  = 8,
  parameter int YELLOW_CYC = 2,
  parameter int ALLRED_CYC = 1,
  parameter int CNT_W      = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       side_req,
  input  logic       ped_req,
  output logic [2:0] main_lt,
  output logic [2:0] side_lt,
  output logic       ped_walk,
  output logic       ped_pending,
  output logic       sel,
  output logic [2:0] dbg_state
);

  typedef enum logic [2:0] {
    MAIN_G = 3'd0,
    MAIN_Y = 3'd1,
    ALL_R1 = 3'd2,
    SIDE_G = 3'd3,
    SIDE_Y = 3'd4,
    ALL_R2 = 3'd5
  } state_e;

  // The timer is loaded with N-1 on entry, so a phase of N lasts N cycles.
  localparam logic [CNT_W-1:0] GREEN_LD  = CNT_W'(GREEN_CYC - 1);
  localparam logic [CNT_W-1:0] YELLOW_LD = CNT_W'(YELLOW_CYC - 1);
  localparam logic [CNT_W-1:0] ALLRED_LD = CNT_W'(ALLRED_CYC - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ped_q, ped_d;
  logic             reload;
  logic             cnt_zero;
  logic [CNT_W-1:0] load_val;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MAIN_G;
      cnt_q   <= GREEN_LD;
      ped_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ped_q   <= ped_d;
    end
  end

  assign cnt_zero = (cnt_q == '0);

  // Next state, timer and pedestrian latch.
  always_comb begin
    state_d  = state_q;
    reload   = 1'b0;
    load_val = ALLRED_LD;
    cnt_d    = cnt_q;
    ped_d    = ped_q;

    case (state_q)
      // Once the minimum green has run out, MAIN_G waits with the timer
      // parked at zero. The first request then exits on the next edge.
      MAIN_G: if (cnt_zero && (side_req || ped_q)) state_d = MAIN_Y;
      MAIN_Y: if (cnt_zero) state_d = ALL_R1;
      ALL_R1: if (cnt_zero) state_d = SIDE_G;
      SIDE_G: if (cnt_zero) state_d = SIDE_Y;
      SIDE_Y: if (cnt_zero) state_d = ALL_R2;
      ALL_R2: if (cnt_zero) state_d = MAIN_G;
      default: begin
        // An unused encoding recovers to main green with a fresh timer.
        state_d = MAIN_G;
        reload  = 1'b1;
      end
    endcase

    if (state_d != state_q) reload = 1'b1;

    case (state_d)
      MAIN_G, SIDE_G: load_val = GREEN_LD;
      MAIN_Y, SIDE_Y: load_val = YELLOW_LD;
      default:        load_val = ALLRED_LD;
    endcase

    if (reload)         cnt_d = load_val;
    else if (!cnt_zero) cnt_d = cnt_q - CNT_W'(1);

    // A request made during SIDE_G, or while entering it, is served by that
    // phase, so it is not latched. Entering SIDE_G clears the latch, and the
    // clear takes priority over a set in the same cycle.
    if (ped_req && (state_q != SIDE_G) && (state_d != SIDE_G)) ped_d = 1'b1;
    if ((state_d == SIDE_G) && (state_q != SIDE_G))            ped_d = 1'b0;
  end

  // Moore output decode: outputs depend only on registers.
  always_comb begin
    main_lt  = 3'b100;
    side_lt  = 3'b100;
    sel      = 1'b0;
    ped_walk = 1'b0;
    case (state_q)
      MAIN_G: main_lt = 3'b001;
      MAIN_Y: main_lt = 3'b010;
      SIDE_G: begin
        side_lt  = 3'b001;
        sel      = 1'b1;
        ped_walk = 1'b1;
      end
      SIDE_Y: begin
        side_lt = 3'b010;
        sel     = 1'b1;
      end
      default: ;
    endcase
  end

  assign ped_pending = ped_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
module tb_traffic_light_ctrl;

  // Phase codes used by the bench's own expectation tables.
  localparam int P_MG = 0, P_MY = 1, P_AR1 = 2, P_SG = 3, P_SY = 4, P_AR2 = 5;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n, side_req, ped_req;
  logic [2:0] main_lt, side_lt, dbg_state;
  logic ped_walk, ped_pending, sel;

  logic rst_n_s, side_req_s, ped_req_s;
  logic [2:0] main_lt_s, side_lt_s, dbg_state_s;
  logic ped_walk_s, ped_pending_s, sel_s;

  int checks = 0;
  int errors = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  traffic_light_ctrl dut (
    .clk(clk), .rst_n(rst_n), .side_req(side_req), .ped_req(ped_req),
    .main_lt(main_lt), .side_lt(side_lt), .ped_walk(ped_walk),
    .ped_pending(ped_pending), .sel(sel), .dbg_state(dbg_state)
  );

  traffic_light_ctrl #(.GREEN_CYC(1), .YELLOW_CYC(1), .ALLRED_CYC(1), .CNT_W(4)) dut_s (
    .clk(clk), .rst_n(rst_n_s), .side_req(side_req_s), .ped_req(ped_req_s),
    .main_lt(main_lt_s), .side_lt(side_lt_s), .ped_walk(ped_walk_s),
    .ped_pending(ped_pending_s), .sel(sel_s), .dbg_state(dbg_state_s)
  );

  // Expected {main_lt, side_lt, sel, ped_walk} for a phase.
  function automatic logic [7:0] lamp_of(input int ph);
    case (ph)
      P_MG:    lamp_of = {3'b001, 3'b100, 1'b0, 1'b0};
      P_MY:    lamp_of = {3'b010, 3'b100, 1'b0, 1'b0};
      P_SG:    lamp_of = {3'b100, 3'b001, 1'b1, 1'b1};
      P_SY:    lamp_of = {3'b100, 3'b010, 1'b1, 1'b0};
      default: lamp_of = {3'b100, 3'b100, 1'b0, 1'b0};
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  // Every step lands on a falling edge: outputs are sampled there, and inputs
  // driven there are seen by the next rising edge.
  task automatic adv();
    @(negedge clk);
  endtask

  // Leaves the bench on a falling edge in cycle 0 (rst_n just released).
  task automatic reset_main();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [7:0] got;
    #2;  // before the first rising edge: only the async reset acts
    got = {main_lt, side_lt, sel, ped_walk};
    checks++;
    if (got !== lamp_of(P_MG)) begin
      errors++;
      $display("FAIL reset_lamps: got %b expected %b", got, lamp_of(P_MG));
    end
    checks++;
    if (ped_pending !== 1'b0) begin
      errors++;
      $display("FAIL reset_ped_pending: got %b expected 0", ped_pending);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_idle();
    logic [7:0] got;
    side_req = 1'b0;
    ped_req  = 1'b0;
    reset_main();
    for (int k = 0; k < 50; k++) begin
      got = {main_lt, side_lt, sel, ped_walk};
      checks++;
      if (got !== lamp_of(P_MG)) begin
        errors++;
        $display("FAIL idle cycle %0d: got %b expected %b", k, got, lamp_of(P_MG));
      end
      adv();
    end
  endtask

  task automatic test_full_cycle();
    logic [7:0] got;
    int ph;
    side_req = 1'b1;
    ped_req  = 1'b0;
    reset_main();
    for (int k = 0; k <= 30; k++) begin
      if (k <= 7)       ph = P_MG;
      else if (k <= 9)  ph = P_MY;
      else if (k == 10) ph = P_AR1;
      else if (k <= 18) ph = P_SG;
      else if (k <= 20) ph = P_SY;
      else if (k == 21) ph = P_AR2;
      else if (k <= 29) ph = P_MG;
      else              ph = P_MY;
      got = {main_lt, side_lt, sel, ped_walk};
      checks++;
      if (got !== lamp_of(ph)) begin
        errors++;
        $display("FAIL full_cycle cycle %0d: got %b expected %b", k, got, lamp_of(ph));
      end
      checks++;
      if (main_lt[2] !== 1'b1 && side_lt[2] !== 1'b1) begin
        errors++;
        $display("FAIL both_non_red cycle %0d: main %b side %b", k, main_lt, side_lt);
      end
      adv();
    end
    side_req = 1'b0;
  endtask

  task automatic test_late_request();
    logic [7:0] got;
    int ph;
    side_req = 1'b0;
    ped_req  = 1'b0;
    reset_main();
    for (int k = 0; k <= 32; k++) begin
      if (k <= 20)      ph = P_MG;
      else if (k <= 22) ph = P_MY;
      else if (k == 23) ph = P_AR1;
      else if (k <= 31) ph = P_SG;
      else              ph = P_SY;
      got = {main_lt, side_lt, sel, ped_walk};
      checks++;
      if (got !== lamp_of(ph)) begin
        errors++;
        $display("FAIL late_request cycle %0d: got %b expected %b", k, got, lamp_of(ph));
      end
      side_req = (k == 20);
      adv();
    end
    side_req = 1'b0;
  endtask

  task automatic test_pedestrian();
    logic [7:0] got;
    logic exp_pend;
    int ph;
    side_req = 1'b0;
    ped_req  = 1'b0;
    reset_main();
    for (int k = 0; k <= 31; k++) begin
      if (k <= 7)       ph = P_MG;
      else if (k <= 9)  ph = P_MY;
      else if (k == 10) ph = P_AR1;
      else if (k <= 18) ph = P_SG;
      else if (k <= 20) ph = P_SY;
      else if (k == 21) ph = P_AR2;
      else              ph = P_MG;  // no request left: main rests
      exp_pend = (k >= 4 && k <= 10);
      got = {main_lt, side_lt, sel, ped_walk};
      checks++;
      if (got !== lamp_of(ph)) begin
        errors++;
        $display("FAIL ped_lamps cycle %0d: got %b expected %b", k, got, lamp_of(ph));
      end
      checks++;
      if (ped_pending !== exp_pend) begin
        errors++;
        $display("FAIL ped_pending cycle %0d: got %b expected %b", k, ped_pending, exp_pend);
      end
      // First press in MAIN_G, second press during SIDE_G (ignored).
      ped_req = (k == 3) || (k == 13);
      adv();
    end
    ped_req = 1'b0;
  endtask

  task automatic test_async_reset();
    logic [7:0] got;
    int ph;
    side_req = 1'b1;
    ped_req  = 1'b0;
    reset_main();
    for (int k = 0; k < 13; k++) adv();
    checks++;
    if (sel !== 1'b1) begin
      errors++;
      $display("FAIL async_pre_side_g: sel got %b expected 1", sel);
    end
    #2 rst_n = 1'b0;
    #1;
    got = {main_lt, side_lt, sel, ped_walk};
    checks++;
    if (got !== lamp_of(P_MG)) begin
      errors++;
      $display("FAIL async_reset_lamps: got %b expected %b", got, lamp_of(P_MG));
    end
    checks++;
    if (ped_pending !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_ped: got %b expected 0", ped_pending);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k <= 9; k++) begin
      ph = (k <= 7) ? P_MG : P_MY;
      got = {main_lt, side_lt, sel, ped_walk};
      checks++;
      if (got !== lamp_of(ph)) begin
        errors++;
        $display("FAIL post_reset cycle %0d: got %b expected %b", k, got, lamp_of(ph));
      end
      adv();
    end
    side_req = 1'b0;
  endtask

  task automatic test_param_sweep();
    logic [7:0] got;
    side_req_s = 1'b1;
    ped_req_s  = 1'b0;
    @(negedge clk);
    rst_n_s = 1'b1;
    for (int k = 0; k < 18; k++) begin
      got = {main_lt_s, side_lt_s, sel_s, ped_walk_s};
      checks++;
      if (got !== lamp_of(k % 6)) begin
        errors++;
        $display("FAIL sweep cycle %0d: got %b expected %b", k, got, lamp_of(k % 6));
      end
      adv();
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst_n      = 1'b0;
    side_req   = 1'b0;
    ped_req    = 1'b0;
    rst_n_s    = 1'b0;
    side_req_s = 1'b0;
    ped_req_s  = 1'b0;
    test_reset();
    test_idle();
    test_full_cycle();
    test_late_request();
    test_pedestrian();
    test_async_reset();
    test_param_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
